// File: rtl/ra_2r1w_march_bist.sv
// March-test initiator for a 2R1W register array: writes a background, runs
// ascending/descending read-then-write-inverse passes and checks both read ports.
module ra_2r1w_march_bist #(
  parameter int             DEPTH  = 32,
  parameter int             DW     = 32,
  parameter int             RD_LAT = 1,
  parameter logic [DW-1:0]  BG_PAT = {(DW/2){2'b01}},
  localparam int            AW     = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          fail,
  output logic [7:0]    err_cnt,
  output logic [AW-1:0] fail_adr,
  output logic          fail_port,
  output logic [DW-1:0] fail_exp,
  output logic [DW-1:0] fail_got,
  output logic          strobe,
  output logic          rd_enb_0,
  output logic [AW-1:0] rd_adr_0,
  input  logic [DW-1:0] rd_dat_0,
  output logic          rd_enb_1,
  output logic [AW-1:0] rd_adr_1,
  input  logic [DW-1:0] rd_dat_1,
  output logic          wr_enb_0,
  output logic [AW-1:0] wr_adr_0,
  output logic [DW-1:0] wr_dat_0
);

  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);
  localparam int            DCW  = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  typedef enum logic [3:0] {
    IDLE, WBG, GAP1, RUP, GAP2, RDN, GAP3, RCHK, DRAIN, DONE_S
  } state_t;

  state_t          state_reg, state_next;
  logic [AW-1:0]   addr_reg, addr_next;
  logic            wph_reg, wph_next;
  logic [DCW-1:0]  dcnt_reg, dcnt_next;
  logic            rd_en, wr_en, start_acc;
  logic [DW-1:0]   wdat, exp_w;

  logic [RD_LAT-1:0] vld_pipe;
  logic [DW-1:0]     exp_pipe [RD_LAT];
  logic [AW-1:0]     adr_pipe [RD_LAT];

  logic            m0, m1;
  logic [8:0]      err_sum;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
      addr_reg  <= '0;
      wph_reg   <= 1'b0;
      dcnt_reg  <= '0;
    end else begin
      state_reg <= state_next;
      addr_reg  <= addr_next;
      wph_reg   <= wph_next;
      dcnt_reg  <= dcnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    addr_next  = addr_reg;
    wph_next   = wph_reg;
    dcnt_next  = dcnt_reg;
    rd_en      = 1'b0;
    wr_en      = 1'b0;
    wdat       = '0;
    exp_w      = '0;
    start_acc  = 1'b0;
    case (state_reg)
      IDLE, DONE_S: begin
        if (start) begin
          start_acc  = 1'b1;
          state_next = WBG;
          addr_next  = '0;
        end
      end
      WBG: begin
        wr_en = 1'b1;
        wdat  = BG_PAT;
        if (addr_reg == LAST) begin
          state_next = GAP1;
          addr_next  = '0;
        end else begin
          addr_next = addr_reg + AW'(1);
        end
      end
      GAP1: begin
        state_next = RUP;
        addr_next  = '0;
        wph_next   = 1'b0;
      end
      RUP: begin
        if (!wph_reg) begin
          rd_en    = 1'b1;
          exp_w    = BG_PAT;
          wph_next = 1'b1;
        end else begin
          wr_en    = 1'b1;
          wdat     = ~BG_PAT;
          wph_next = 1'b0;
          if (addr_reg == LAST) begin
            state_next = GAP2;
            addr_next  = LAST;
          end else begin
            addr_next = addr_reg + AW'(1);
          end
        end
      end
      GAP2: begin
        state_next = RDN;
        addr_next  = LAST;
        wph_next   = 1'b0;
      end
      RDN: begin
        if (!wph_reg) begin
          rd_en    = 1'b1;
          exp_w    = ~BG_PAT;
          wph_next = 1'b1;
        end else begin
          wr_en    = 1'b1;
          wdat     = BG_PAT;
          wph_next = 1'b0;
          if (addr_reg == '0) begin
            state_next = GAP3;
          end else begin
            addr_next = addr_reg - AW'(1);
          end
        end
      end
      GAP3: begin
        state_next = RCHK;
        addr_next  = '0;
      end
      RCHK: begin
        rd_en = 1'b1;
        exp_w = BG_PAT;
        if (addr_reg == LAST) begin
          state_next = DRAIN;
          dcnt_next  = '0;
        end else begin
          addr_next = addr_reg + AW'(1);
        end
      end
      DRAIN: begin
        if (dcnt_reg == DCW'(RD_LAT - 1)) state_next = DONE_S;
        else                              dcnt_next  = dcnt_reg + DCW'(1);
      end
      default: state_next = IDLE;
    endcase
  end

  // Expected word/address travel with the read enable so the compare lines up with returned data.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_pipe <= '0;
      for (int i = 0; i < RD_LAT; i++) begin
        exp_pipe[i] <= '0;
        adr_pipe[i] <= '0;
      end
    end else begin
      vld_pipe[0] <= rd_en;
      exp_pipe[0] <= exp_w;
      adr_pipe[0] <= addr_reg;
      for (int i = 1; i < RD_LAT; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
        exp_pipe[i] <= exp_pipe[i-1];
        adr_pipe[i] <= adr_pipe[i-1];
      end
    end
  end

  assign m0      = vld_pipe[RD_LAT-1] && (rd_dat_0 != exp_pipe[RD_LAT-1]);
  assign m1      = vld_pipe[RD_LAT-1] && (rd_dat_1 != exp_pipe[RD_LAT-1]);
  assign err_sum = {1'b0, err_cnt} + 9'(m0) + 9'(m1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fail      <= 1'b0;
      err_cnt   <= '0;
      fail_adr  <= '0;
      fail_port <= 1'b0;
      fail_exp  <= '0;
      fail_got  <= '0;
    end else if (start_acc) begin
      fail      <= 1'b0;
      err_cnt   <= '0;
      fail_adr  <= '0;
      fail_port <= 1'b0;
      fail_exp  <= '0;
      fail_got  <= '0;
    end else if (m0 || m1) begin
      fail    <= 1'b1;
      err_cnt <= err_sum[8] ? 8'hFF : err_sum[7:0];
      if (!fail) begin
        fail_adr  <= adr_pipe[RD_LAT-1];
        fail_port <= !m0;
        fail_exp  <= exp_pipe[RD_LAT-1];
        fail_got  <= m0 ? rd_dat_0 : rd_dat_1;
      end
    end
  end

  assign busy     = (state_reg != IDLE) && (state_reg != DONE_S);
  assign done     = (state_reg == DONE_S);
  assign strobe   = rd_en | wr_en;
  assign rd_enb_0 = rd_en;
  assign rd_enb_1 = rd_en;
  assign rd_adr_0 = rd_en ? addr_reg : '0;
  assign rd_adr_1 = rd_en ? addr_reg : '0;
  assign wr_enb_0 = wr_en;
  assign wr_adr_0 = wr_en ? addr_reg : '0;
  assign wr_dat_0 = wdat;

endmodule

// File: tb/tb_ra_2r1w_march_bist.sv
// Bench for ra_2r1w_march_bist: behavioural 32x32 array with optional faults,
// table of full-run vectors plus reset/abort and ignored-start sequences.
module tb_ra_2r1w_march_bist;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        busy, done, fail, fail_port, strobe;
  logic [7:0]  err_cnt;
  logic [4:0]  fail_adr, rd_adr_0, rd_adr_1, wr_adr_0;
  logic [31:0] fail_exp, fail_got, rd_dat_0, rd_dat_1, wr_dat_0;
  logic        rd_enb_0, rd_enb_1, wr_enb_0;

  int n_cmp = 0;
  int n_err = 0;
  int viol  = 0;
  int fault = 0; // 0 none, 1 bit3 stuck-at-0 at adr 8, 2 port1 bit31 inverted at adr 0

  logic [31:0] mem [32];
  logic        any_out;

  ra_2r1w_march_bist dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done), .fail(fail),
    .err_cnt(err_cnt), .fail_adr(fail_adr), .fail_port(fail_port),
    .fail_exp(fail_exp), .fail_got(fail_got), .strobe(strobe),
    .rd_enb_0(rd_enb_0), .rd_adr_0(rd_adr_0), .rd_dat_0(rd_dat_0),
    .rd_enb_1(rd_enb_1), .rd_adr_1(rd_adr_1), .rd_dat_1(rd_dat_1),
    .wr_enb_0(wr_enb_0), .wr_adr_0(wr_adr_0), .wr_dat_0(wr_dat_0)
  );

  always #5 clk = ~clk;

  assign any_out = |{busy, done, fail, err_cnt, fail_adr, fail_port, fail_exp, fail_got,
                     strobe, rd_enb_0, rd_adr_0, rd_enb_1, rd_adr_1, wr_enb_0, wr_adr_0, wr_dat_0};

  // Array model, one-cycle read latency.
  always @(posedge clk) begin
    if (wr_enb_0)
      mem[wr_adr_0] <= (fault == 1 && wr_adr_0 == 5'd8) ? (wr_dat_0 & ~32'h8) : wr_dat_0;
    if (rd_enb_0) rd_dat_0 <= mem[rd_adr_0];
    if (rd_enb_1)
      rd_dat_1 <= mem[rd_adr_1] ^ ((fault == 2 && rd_adr_1 == 5'd0) ? 32'h8000_0000 : 32'h0);
  end

  always @(negedge clk) begin
    if (reset) begin
      if ((rd_enb_0 || rd_enb_1) && wr_enb_0) viol++;
      if (rd_enb_0 != rd_enb_1 || (rd_enb_0 && rd_adr_0 != rd_adr_1)) viol++;
      if (strobe != (rd_enb_0 | rd_enb_1 | wr_enb_0)) viol++;
    end
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h expected=%0h", name, got, exp);
    end
  endtask

  task automatic run(input bit extra, output int nb, output int nw, output int nr);
    nb = 0; nw = 0; nr = 0;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    chk("start_clears_results", {61'd0, done, fail, |err_cnt}, 64'd0);
    while (busy && nb < 400) begin
      nb++;
      if (wr_enb_0) nw++;
      if (rd_enb_0) nr++;
      start = (extra && (nb == 10 || nb == 100));
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  typedef struct {
    int          flt;
    bit          extra;
    logic        fail;
    logic [7:0]  err;
    logic [4:0]  adr;
    logic        port;
    logic [31:0] exp;
    logic [31:0] got;
  } vec_t;

  vec_t vecs [4];

  initial begin
    int nb, nw, nr, idle_strobes;

    vecs[0] = '{0, 1'b0, 1'b0, 8'd0, 5'd0, 1'b0, 32'h0, 32'h0};
    vecs[1] = '{1, 1'b0, 1'b1, 8'd2, 5'd8, 1'b0, 32'hAAAA_AAAA, 32'hAAAA_AAA2};
    vecs[2] = '{2, 1'b0, 1'b1, 8'd3, 5'd0, 1'b1, 32'h5555_5555, 32'hD555_5555};
    vecs[3] = '{0, 1'b1, 1'b0, 8'd0, 5'd0, 1'b0, 32'h0, 32'h0};

    // Asynchronous reset mid-cycle
    #3 reset = 1'b0;
    #1 chk("reset_outputs_zero", {63'd0, any_out}, 64'd0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    idle_strobes = 0;
    repeat (5) begin
      @(negedge clk);
      if (strobe || busy) idle_strobes++;
    end
    chk("idle_after_reset", idle_strobes, 0);

    for (int v = 0; v < 4; v++) begin
      fault = vecs[v].flt;
      run(vecs[v].extra, nb, nw, nr);
      $display("run %0d: fault=%0d busy=%0d wr=%0d rd=%0d fail=%0b err=%0d adr=%0d port=%0b exp=%h got=%h",
               v, fault, nb, nw, nr, fail, err_cnt, fail_adr, fail_port, fail_exp, fail_got);
      chk("busy_cycles", nb, 196);
      chk("write_cycles", nw, 96);
      chk("read_cycles", nr, 96);
      chk("done", {63'd0, done}, 64'd1);
      chk("fail", {63'd0, fail}, {63'd0, vecs[v].fail});
      chk("err_cnt", err_cnt, vecs[v].err);
      if (vecs[v].fail) begin
        chk("fail_adr", fail_adr, vecs[v].adr);
        chk("fail_port", {63'd0, fail_port}, {63'd0, vecs[v].port});
        chk("fail_exp", fail_exp, vecs[v].exp);
        chk("fail_got", fail_got, vecs[v].got);
      end
    end

    // Results held in DONE for a few cycles
    repeat (4) @(negedge clk);
    chk("done_held", {62'd0, done, busy}, 64'd2);

    // Abort at busy cycle 50 with a fault active, then a clean run
    fault = 2;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    nb = 1;
    while (nb < 50) begin
      @(negedge clk);
      nb++;
    end
    chk("err_before_abort", err_cnt, 8'd1);
    #2 reset = 1'b0;
    #1 chk("abort_outputs_zero", {63'd0, any_out}, 64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    idle_strobes = 0;
    repeat (5) begin
      @(negedge clk);
      if (strobe || busy) idle_strobes++;
    end
    chk("idle_after_abort", idle_strobes, 0);
    fault = 0;
    run(1'b0, nb, nw, nr);
    $display("run post-abort: busy=%0d wr=%0d rd=%0d fail=%0b err=%0d", nb, nw, nr, fail, err_cnt);
    chk("abort_busy_cycles", nb, 196);
    chk("abort_write_cycles", nw, 96);
    chk("abort_read_cycles", nr, 96);
    chk("abort_done_clean", {61'd0, done, fail, |err_cnt}, 64'd4);

    chk("protocol_violations", viol, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
